count_monitor: RTL and testbench

Downstream checker and display stage for the 3-bit complex counter. It samples `Count` and `Mode` on the rising edge of the shared clock, which is half a period after the counter updates on the falling edge. It checks every step against the binary (`Mode`=0) or Gray (`Mode`=1) successor table and decodes the count to a sequence index and a 7-segment pattern. It also keeps lock status, wrap statistics and error statistics for the board-level status logic.

---
 rtl/count_pkg.sv | 33 +++
 rtl/count_monitor_if.sv | 24 ++
 rtl/count_monitor_seg7.sv | 9 +
 rtl/count_monitor.sv | 105 ++++++++++
 tb/tb_count_monitor.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared state enum, mode constants, successor/gray helpers and seven-segment table
package count_pkg;

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;

    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;

    // Active-low {g,f,e,d,c,b,a}; entry i shows digit i.
    localparam logic [7:0][6:0] SEG_TABLE = {
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = g[2] ^ g[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [2:0] bin2gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [2:0] succ(input logic [2:0] count, input logic mode);
        if (mode == MODE_GRAY)
            return bin2gray(gray2bin(count) + 3'd1);
        return count + 3'd1;
    endfunction

endpackage

// File: rtl/count_monitor_if.sv
// rtl/count_monitor_if.sv - counter sample inputs and monitor status outputs
interface count_monitor_if #(
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) ();
    logic              Mode;
    logic [2:0]        Count;
    logic [2:0]        Index;
    logic [6:0]        Seg;
    logic              Locked;
    logic              ErrFlag;
    logic [ERR_W-1:0]  ErrCnt;
    logic [WRAP_W-1:0] WrapCnt;

    modport master (
        output Mode, Count,
        input  Index, Seg, Locked, ErrFlag, ErrCnt, WrapCnt
    );

    modport slave (
        input  Mode, Count,
        output Index, Seg, Locked, ErrFlag, ErrCnt, WrapCnt
    );
endinterface

// File: rtl/count_monitor_seg7.sv
// rtl/count_monitor_seg7.sv - combinational 3-bit digit to active-low seven-segment lookup
module seg7_decoder
    import count_pkg::*;
(
    input  logic [2:0] digit,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[digit];
endmodule

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - successor checker, lock FSM, index/segment display and error/wrap statistics
module count_monitor
    import count_pkg::*;
#(
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
) (
    input  logic            Clk,
    input  logic            nReset,
    count_monitor_if.slave  mon
);
    localparam logic [3:0] LOCK_TGT = 4'(LOCK_N);

    state_t            state, state_nx;
    logic [3:0]        good, good_nx;
    logic [2:0]        prev;
    logic [2:0]        index, index_nx;
    logic [6:0]        seg, seg_nx;
    logic              err_flag;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              hit, err_inc, wrap_inc;

    // Checked against the current mode: a mode switch reaches the counter one edge early.
    assign hit      = (mon.Count == succ(prev, mon.Mode));
    assign index_nx = (mon.Mode == MODE_GRAY) ? gray2bin(mon.Count) : mon.Count;

    // Decode the incoming index so Seg lands on the same edge as Index.
    seg7_decoder u_seg7 (
        .digit (index_nx),
        .seg   (seg_nx)
    );

    always_comb begin
        state_nx = state;
        good_nx  = good;
        err_inc  = 1'b0;
        wrap_inc = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = ACQ;
                good_nx  = 4'd0;
            end
            ACQ: begin
                if (hit) begin
                    good_nx = good + 4'd1;
                    if (good + 4'd1 == LOCK_TGT)
                        state_nx = LOCKED;
                end else begin
                    good_nx = 4'd0;
                end
            end
            LOCKED: begin
                if (hit) begin
                    // A correct step landing on 000 is always index 7 -> 0 in either mode.
                    wrap_inc = (mon.Count == 3'b000);
                end else begin
                    state_nx = FAULT;
                    err_inc  = 1'b1;
                end
            end
            FAULT: begin
                state_nx = ACQ;
                good_nx  = 4'd0;
            end
            default: begin
                state_nx = IDLE;
                good_nx  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state    <= IDLE;
            good     <= 4'd0;
            prev     <= 3'd0;
            index    <= 3'd0;
            seg      <= SEG_TABLE[0];
            err_flag <= 1'b0;
            err_cnt  <= '0;
            wrap_cnt <= '0;
        end else begin
            state    <= state_nx;
            good     <= good_nx;
            prev     <= mon.Count;
            index    <= index_nx;
            seg      <= seg_nx;
            err_flag <= err_flag | err_inc;
            if (err_inc && (err_cnt != {ERR_W{1'b1}}))
                err_cnt <= err_cnt + 1'b1;
            if (wrap_inc)
                wrap_cnt <= wrap_cnt + 1'b1;
        end
    end

    assign mon.Index   = index;
    assign mon.Seg     = seg;
    assign mon.Locked  = (state == LOCKED);
    assign mon.ErrFlag = err_flag;
    assign mon.ErrCnt  = err_cnt;
    assign mon.WrapCnt = wrap_cnt;

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - randomized and directed bench for count_monitor against a sequence-level model
module tb_count_monitor;

    localparam int LOCK_N = 4;
    localparam int ERR_W  = 8;
    localparam int WRAP_W = 8;

    logic clk = 1'b0;
    logic n_reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    count_monitor_if #(.ERR_W(ERR_W), .WRAP_W(WRAP_W)) bus ();

    count_monitor #(.LOCK_N(LOCK_N), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) dut (
        .Clk    (clk),
        .nReset (n_reset),
        .mon    (bus.slave)
    );

    int         gray_seq [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    logic [6:0] seg_ref  [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    function automatic int idx_of(input int c, input bit m);
        if (!m) return c;
        for (int i = 0; i < 8; i++)
            if (gray_seq[i] == c) return i;
        return 0;
    endfunction

    function automatic int next_of(input int c, input bit m);
        if (!m) return (c + 1) % 8;
        return gray_seq[(idx_of(c, 1'b1) + 1) % 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sequence-level model: baseline held, consecutive good run, locked flag, skip-after-fault.
    bit m_base, m_skip, m_locked, m_err;
    int m_run, m_errcnt, m_wrap, m_prev, m_index;

    always @(posedge clk) begin
        int  s;
        bit  m;
        #1;
        s = int'(bus.Count);
        m = bus.Mode;
        if (!n_reset) begin
            m_base = 0; m_skip = 0; m_locked = 0; m_err = 0;
            m_run = 0; m_errcnt = 0; m_wrap = 0; m_prev = 0; m_index = 0;
        end else begin
            m_index = idx_of(s, m);
            if (!m_base || m_skip) begin
                m_base = 1; m_skip = 0; m_run = 0; m_locked = 0;
            end else if (s == next_of(m_prev, m)) begin
                if (m_locked) begin
                    if (idx_of(m_prev, m) == 7 && m_index == 0) m_wrap++;
                end else begin
                    m_run++;
                    if (m_run == LOCK_N) m_locked = 1;
                end
            end else if (m_locked) begin
                m_locked = 0; m_skip = 1; m_err = 1;
                if (m_errcnt < (1 << ERR_W) - 1) m_errcnt++;
            end else begin
                m_run = 0;
            end
            m_prev = s;
        end
        check("index",   bus.Index,   m_index);
        check("seg",     bus.Seg,     seg_ref[m_index]);
        check("locked",  bus.Locked,  m_locked);
        check("errflag", bus.ErrFlag, m_err);
        check("errcnt",  bus.ErrCnt,  m_errcnt);
        check("wrapcnt", bus.WrapCnt, m_wrap % (1 << WRAP_W));
    end

    int cur;
    bit mode;

    task automatic step(input int c, input bit m, input bit r);
        @(negedge clk);
        bus.Count = c[2:0];
        bus.Mode  = m;
        n_reset   = r;
        cur  = c;
        mode = m;
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_index"},   bus.Index,   0);
        check({tag, "_seg"},     bus.Seg,     7'b1000000);
        check({tag, "_locked"},  bus.Locked,  0);
        check({tag, "_errflag"}, bus.ErrFlag, 0);
        check({tag, "_errcnt"},  bus.ErrCnt,  0);
        check({tag, "_wrapcnt"}, bus.WrapCnt, 0);
    endtask

    initial begin
        n_reset   = 1'b0;
        bus.Count = 3'd0;
        bus.Mode  = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        check_reset_values("rst0");

        // Binary count from 0: lock on the 5th sample, wrap after the first 7 -> 0.
        for (int v = 0; v < 8; v++) begin
            step(v, 0, 1);
            if (v == 3) begin
                check("bin_locked_v3", bus.Locked, 0);
                check("bin_seg_3", bus.Seg, 7'b0110000);
                check("bin_index_3", bus.Index, 3);
            end
            if (v == 4) check("bin_locked_v4", bus.Locked, 1);
        end
        step(0, 0, 1);
        check("bin_wrap1", bus.WrapCnt, 1);
        for (int v = 1; v < 4; v++) step(v, 0, 1);

        // Mode change after 011: 010 is the Gray successor, index 3.
        step(3'b010, 1, 1);
        check("mode_sw_locked", bus.Locked, 1);
        check("mode_sw_index", bus.Index, 3);
        check("mode_sw_err", bus.ErrFlag, 0);
        step(3'b110, 1, 1); step(3'b111, 1, 1); step(3'b101, 1, 1); step(3'b100, 1, 1);
        check("gray_index7", bus.Index, 7);
        step(3'b000, 1, 1);
        check("gray_wrap2", bus.WrapCnt, 2);

        // Binary fault 010 -> 101, then relock after four good steps.
        step(3'b001, 0, 1); step(3'b010, 0, 1); step(3'b101, 0, 1);
        check("fault_flag", bus.ErrFlag, 1);
        check("fault_cnt", bus.ErrCnt, 1);
        check("fault_locked", bus.Locked, 0);
        step(3'b110, 0, 1); step(3'b111, 0, 1); step(3'b000, 0, 1); step(3'b001, 0, 1);
        check("relock_pre", bus.Locked, 0);
        step(3'b010, 0, 1);
        check("relock", bus.Locked, 1);

        // Hold while locked is an error; hold during acquisition is not.
        step(3'b010, 0, 1);
        check("hold_locked_cnt", bus.ErrCnt, 2);
        step(3'b011, 0, 1); step(3'b100, 0, 1); step(3'b100, 0, 1);
        check("hold_acq_cnt", bus.ErrCnt, 2);
        check("hold_acq_locked", bus.Locked, 0);

        // Random walk: mostly correct successors, occasional mode flips and glitches.
        for (int i = 0; i < 600; i++) begin
            int r;
            bit m;
            r = $urandom_range(99);
            m = mode;
            if (r < 10) m = ~m;
            if (r < 88) step(next_of(cur, m), m, 1);
            else        step($urandom_range(7), m, 1);
        end

        // 300 faults: hold, rebaseline, four good steps to relock.
        for (int i = 0; i < 300; i++) begin
            step(cur, 0, 1);
            step($urandom_range(7), 0, 1);
            for (int j = 0; j < 4; j++) step(next_of(cur, 0), 0, 1);
        end
        check("sat_errcnt", bus.ErrCnt, 255);
        check("sat_errflag", bus.ErrFlag, 1);

        step(cur, 0, 0);
        check_reset_values("rst1");

        // Wrap counter rollover: 257 locked wraps leave 1.
        for (int v = 0; v < 8; v++) step(v, 0, 1);
        step(0, 0, 1);
        for (int w = 0; w < 256; w++)
            for (int v = 1; v < 9; v++) step(v % 8, 0, 1);
        check("wrap_roll", bus.WrapCnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
